reg_scoreboard: RTL

- Issue-side hazard controller for the architectural register file.
- Tracks outstanding writes per register and gates decode issue until both source operands are safe to read from the register file.
- Supports a jump-flush drain so issue resumes only after all in-flight writebacks retire.
- Sits between decode/issue and the register file's read/write ports.

---
 rtl/reg_scoreboard_pkg.sv | 22 ++
 rtl/reg_scoreboard_entry.sv | 48 ++++
 rtl/reg_scoreboard.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
// Optional same-cycle writeback bypass is selected with the SB_BYPASS_EN macro
// (consumed in reg_scoreboard.sv).
package reg_scoreboard_pkg;

    // Architectural register file geometry.
    localparam int SB_REG_NUM    = 32;
    localparam int SB_REG_ADDR_W = 5;

    // Per-register pending-write counter width and total-outstanding width.
    localparam int SB_CNT_W = 2;
    localparam int SB_OUT_W = 4;

    localparam logic [SB_REG_ADDR_W-1:0] SB_REG_ADDR_ZERO = '0;

    // Scoreboard control state: normal issue, or draining after a flush.
    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One scoreboard entry: pending-write counter for a single register.
// inc and dec arriving together leave the count unchanged; a dec with a zero
// count does not move the counter and is reported on underflow instead.
module reg_scoreboard_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic is_one,
    output logic is_max,
    output logic underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic             dec_eff;

    // Decode counter status flags used by the issue gate.
    always_comb begin
        busy      = (count != '0);
        is_one    = (count == CNT_ONE);
        is_max    = (count == CNT_MAX);
        dec_eff   = dec & busy;
        underflow = dec & ~busy;
    end

    // Saturating up/down counter, frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            case ({inc, dec_eff})
                2'b10:   if (!is_max) count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller for the architectural register file.
// Counts outstanding writes per register, gates decode issue until both
// sources are readable, and drains all in-flight writebacks after a flush.
// Macro SB_BYPASS_EN: a source with exactly one pending write is also
// readable in the cycle its writeback lands (register file write-through).
//
// Handshake: an instruction fires in a cycle where issue_valid and
// issue_ready are both high; issue_ready is combinational and does not
// depend on issue_valid. wb_valid has no back-pressure.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_NUM    = SB_REG_NUM,
    parameter int REG_ADDR_W = SB_REG_ADDR_W,
    parameter int CNT_W      = SB_CNT_W,
    parameter int OUT_W      = SB_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  rd_write,
    output logic                  issue_ready,
    output logic                  rf_read_enable1,
    output logic                  rf_read_enable2,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic                  draining,
    output logic [OUT_W-1:0]      outstanding,
    output logic                  err_underflow
);

`ifdef SB_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    sb_state_e state;
    sb_state_e state_next;
    logic      run_mode;

    logic [REG_NUM-1:0] busy_v;
    logic [REG_NUM-1:0] one_v;
    logic [REG_NUM-1:0] max_v;
    logic [REG_NUM-1:0] uf_v;
    logic [REG_NUM-1:1] inc_v;
    logic [REG_NUM-1:1] dec_v;

    logic             fire;
    logic             src1_ok;
    logic             src2_ok;
    logic             rd_full;
    logic             wb_hit;
    logic             out_inc;
    logic [OUT_W-1:0] out_next;

    // x0 is never tracked: its status bits are constant zero.
    assign busy_v[0] = 1'b0;
    assign one_v[0]  = 1'b0;
    assign max_v[0]  = 1'b0;
    assign uf_v[0]   = 1'b0;

    generate
        for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
            reg_scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
                .clk       (clk),
                .rst       (rst),
                .en        (rdy),
                .inc       (inc_v[r]),
                .dec       (dec_v[r]),
                .busy      (busy_v[r]),
                .is_one    (one_v[r]),
                .is_max    (max_v[r]),
                .underflow (uf_v[r])
            );
        end
    endgenerate

    // Issue gate: sources readable, destination and total counters not full.
    always_comb begin
        src1_ok = ~rs1_used | (issue_rs1 == SB_REG_ADDR_ZERO) | ~busy_v[issue_rs1]
                | (BYPASS_ON & one_v[issue_rs1] & wb_valid & (wb_rd == issue_rs1));
        src2_ok = ~rs2_used | (issue_rs2 == SB_REG_ADDR_ZERO) | ~busy_v[issue_rs2]
                | (BYPASS_ON & one_v[issue_rs2] & wb_valid & (wb_rd == issue_rs2));
        rd_full = rd_write & (issue_rd != SB_REG_ADDR_ZERO) & max_v[issue_rd];
        issue_ready = rdy & ~rst & run_mode & ~flush & src1_ok & src2_ok
                    & ~rd_full & (outstanding != OUT_MAX);
        fire            = issue_valid & issue_ready;
        rf_read_enable1 = fire & rs1_used;
        rf_read_enable2 = fire & rs2_used;
    end

    // Per-register increment/decrement requests.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc_v[r] = fire & rd_write & (issue_rd == REG_ADDR_W'(r));
            dec_v[r] = wb_valid & (wb_rd == REG_ADDR_W'(r));
        end
    end

    // Next total-outstanding value; simultaneous issue and retire cancel out.
    always_comb begin
        out_inc  = fire & rd_write & (issue_rd != SB_REG_ADDR_ZERO);
        wb_hit   = wb_valid & (wb_rd != SB_REG_ADDR_ZERO) & busy_v[wb_rd];
        out_next = outstanding;
        if (out_inc & ~wb_hit) begin
            out_next = outstanding + 1'b1;
        end else if (~out_inc & wb_hit) begin
            out_next = outstanding - 1'b1;
        end
    end

    // Total-outstanding register, frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (rdy) begin
            outstanding <= out_next;
        end
    end

    // Sticky underflow flag: writeback to a register with nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (rdy && (|uf_v)) begin
            err_underflow <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SB_RUN;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    // FSM next state: enter drain on flush, leave once nothing is in flight.
    always_comb begin
        state_next = state;
        case (state)
            SB_RUN:   if (flush) state_next = SB_DRAIN;
            SB_DRAIN: if (!flush && (out_next == '0)) state_next = SB_RUN;
            default:  state_next = SB_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run_mode = (state == SB_RUN);
        draining = (state == SB_DRAIN);
    end

endmodule
